// File: rtl/decoder_onehot_stream.sv
// Address-to-one-hot decoder behind a 2-entry skid FIFO; the optional ZERO_LINE_MASK_EN build masks line 0.
// Latency: one cycle from an accepted address to a valid decoded beat on Out, with full throughput and no bubbles.
// Backpressure: in_ready drops only when both entries are full, and it depends on state alone, never on out_ready.
module decoder_onehot_stream #(
    parameter int OUTPUTS = 32,
    parameter int ADDR    = 5,
    parameter int ERR_W   = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [ADDR-1:0]    Addr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OUTPUTS-1:0] Out,
    output logic               out_err,
    output logic [ERR_W-1:0]   err_cnt
);

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    // One extra bit so that OUTPUTS == 2**ADDR is still representable.
    localparam logic [ADDR:0] LIMIT = (ADDR+1)'(OUTPUTS);

    state_t             state, state_nxt;
    logic [OUTPUTS-1:0] head_vec, tail_vec, dec_vec;
    logic               head_err, tail_err, dec_err;
    logic               push, pop;
    logic               head_from_in, head_from_tail, tail_from_in;

    assign in_ready  = (state != TWO);
    assign out_valid = (state != EMPTY);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign Out       = out_valid ? head_vec : '0;
    assign out_err   = out_valid & head_err;

    always_comb begin
        dec_vec = '0;
        dec_err = 1'b0;
        if ({1'b0, Addr} < LIMIT) begin
            for (int i = 0; i < OUTPUTS; i++) begin
                dec_vec[i] = (Addr == ADDR'(i));
            end
`ifdef ZERO_LINE_MASK_EN
            if (Addr == '0) begin
                dec_vec = '0;
            end
`endif
        end else begin
            dec_err = 1'b1;
        end
    end

    always_comb begin
        state_nxt      = state;
        head_from_in   = 1'b0;
        head_from_tail = 1'b0;
        tail_from_in   = 1'b0;
        case (state)
            EMPTY: begin
                if (push) begin
                    state_nxt    = ONE;
                    head_from_in = 1'b1;
                end
            end
            ONE: begin
                if (push && !pop) begin
                    state_nxt    = TWO;
                    tail_from_in = 1'b1;
                end else if (pop && !push) begin
                    state_nxt = EMPTY;
                end else if (push && pop) begin
                    head_from_in = 1'b1;
                end
            end
            TWO: begin
                if (pop) begin
                    state_nxt      = ONE;
                    head_from_tail = 1'b1;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= EMPTY;
            head_vec <= '0;
            head_err <= 1'b0;
            tail_vec <= '0;
            tail_err <= 1'b0;
        end else begin
            state <= state_nxt;
            if (head_from_in) begin
                head_vec <= dec_vec;
                head_err <= dec_err;
            end else if (head_from_tail) begin
                head_vec <= tail_vec;
                head_err <= tail_err;
            end
            if (tail_from_in) begin
                tail_vec <= dec_vec;
                tail_err <= dec_err;
            end
        end
    end

    // Counts at acceptance, so a beat still waiting in the FIFO is already counted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_cnt <= '0;
        end else if (push && dec_err && (err_cnt != '1)) begin
            err_cnt <= err_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_decoder_onehot_stream.sv
// Scoreboard bench: instance a has 32 lines and an 8-bit counter; instance b has 24 lines and a 2-bit counter.
module tb_decoder_onehot_stream;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        iv_a = 0, ir_a, ov_a, or_a = 0, oe_a;
    logic [4:0]  ad_a = 0;
    logic [31:0] out_a;
    logic [7:0]  ec_a;

    logic        iv_b = 0, ir_b, ov_b, or_b = 0, oe_b;
    logic [4:0]  ad_b = 0;
    logic [23:0] out_b;
    logic [1:0]  ec_b;

    decoder_onehot_stream #(.OUTPUTS(32), .ADDR(5), .ERR_W(8)) dut_a (
        .clk(clk), .reset(rst), .in_valid(iv_a), .in_ready(ir_a), .Addr(ad_a),
        .out_valid(ov_a), .out_ready(or_a), .Out(out_a), .out_err(oe_a), .err_cnt(ec_a));

    decoder_onehot_stream #(.OUTPUTS(24), .ADDR(5), .ERR_W(2)) dut_b (
        .clk(clk), .reset(rst), .in_valid(iv_b), .in_ready(ir_b), .Addr(ad_b),
        .out_valid(ov_b), .out_ready(or_b), .Out(out_b), .out_err(oe_b), .err_cnt(ec_b));

    int checks = 0;
    int errors = 0;

    logic [32:0] qa[$];
    logic [32:0] qb[$];
    int cnt_a = 0;
    int cnt_b = 0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Expected entry {err, line vector}: computed from the address and line count directly.
    function automatic logic [32:0] model(input int addr, input int outputs);
        logic [32:0] r;
        r = '0;
        if (addr >= outputs) begin
            r[32] = 1'b1;
        end else begin
`ifdef ZERO_LINE_MASK_EN
            if (addr != 0) r[addr] = 1'b1;
`else
            r[addr] = 1'b1;
`endif
        end
        return r;
    endfunction

    always @(negedge clk) begin
        logic [32:0] e;
        if (rst) begin
            qa.delete();
            cnt_a = 0;
        end else begin
            chk("a_in_ready", 64'(ir_a), 64'(qa.size() < 2));
            chk("a_out_valid", 64'(ov_a), 64'(qa.size() > 0));
            chk("a_err_cnt", 64'(ec_a), 64'(cnt_a));
            if (ov_a && or_a && qa.size() > 0) begin
                e = qa.pop_front();
                chk("a_out", 64'(out_a), 64'(e[31:0]));
                chk("a_out_err", 64'(oe_a), 64'(e[32]));
            end else if (!ov_a) begin
                chk("a_idle_out", 64'({oe_a, out_a}), 64'(0));
            end
            if (iv_a && ir_a) begin
                e = model(int'(ad_a), 32);
                qa.push_back(e);
                if (e[32] && cnt_a < 255) cnt_a++;
            end
        end
    end

    always @(negedge clk) begin
        logic [32:0] e;
        if (rst) begin
            qb.delete();
            cnt_b = 0;
        end else begin
            chk("b_in_ready", 64'(ir_b), 64'(qb.size() < 2));
            chk("b_out_valid", 64'(ov_b), 64'(qb.size() > 0));
            chk("b_err_cnt", 64'(ec_b), 64'(cnt_b));
            if (ov_b && or_b && qb.size() > 0) begin
                e = qb.pop_front();
                chk("b_out", 64'(out_b), 64'(e[23:0]));
                chk("b_out_err", 64'(oe_b), 64'(e[32]));
            end else if (!ov_b) begin
                chk("b_idle_out", 64'({oe_b, out_b}), 64'(0));
            end
            if (iv_b && ir_b) begin
                e = model(int'(ad_b), 24);
                qb.push_back(e);
                if (e[32] && cnt_b < 3) cnt_b++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_a(input logic v, input int a, input logic r);
        iv_a = v; ad_a = 5'(a); or_a = r;
    endtask

    task automatic set_b(input logic v, input int a, input logic r);
        iv_b = v; ad_b = 5'(a); or_b = r;
    endtask

    initial begin
        tick();
        tick();
        chk("rst_a_out_valid", 64'(ov_a), 64'(0));
        chk("rst_a_out", 64'({oe_a, out_a}), 64'(0));
        chk("rst_a_err_cnt", 64'(ec_a), 64'(0));
        rst = 1'b0;
        #1;
        chk("rst_a_in_ready", 64'(ir_a), 64'(1));

        // Single beat, then back-pressure with 3, 7 and a held 9.
        set_a(1, 5, 1); tick();
        set_a(0, 0, 1); tick();
        set_a(1, 3, 0); tick();
        set_a(1, 7, 0); tick();
        set_a(1, 9, 0); tick(); tick();
        set_a(1, 9, 1); tick(); tick();
        set_a(0, 0, 1); tick(); tick(); tick();

        // Line 0, then a full-rate stream of every address.
        set_a(1, 0, 1); tick();
        for (int i = 0; i < 32; i++) begin
            set_a(1, i, 1); tick();
        end
        set_a(0, 0, 1); tick(); tick();

        // Range errors and counter saturation on the 24-line instance.
        for (int i = 0; i < 5; i++) begin
            set_b(1, 30, 1); tick();
        end
        set_b(1, 23, 1); tick();
        set_b(1, 24, 1); tick();
        set_b(0, 0, 1); tick(); tick();

        // Mid-stream reset with both entries held.
        rst = 1'b1; tick(); rst = 1'b0; tick();
        set_b(1, 30, 0); tick();
        set_b(1, 25, 0); tick();
        set_b(0, 0, 0);
        chk("b_full_in_ready", 64'(ir_b), 64'(0));
        rst = 1'b1;
        #1;
        chk("b_rst_out_valid", 64'(ov_b), 64'(0));
        chk("b_rst_out", 64'({oe_b, out_b}), 64'(0));
        chk("b_rst_err_cnt", 64'(ec_b), 64'(0));
        tick();
        rst = 1'b0;
        #1;
        chk("b_rst_in_ready", 64'(ir_b), 64'(1));
        tick();

        for (int i = 0; i < 1500; i++) begin
            set_a(1'($urandom_range(0, 1)), int'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
            set_b(1'($urandom_range(0, 1)), int'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
            tick();
        end

        set_a(0, 0, 1);
        set_b(0, 0, 1);
        tick(); tick(); tick(); tick();
        chk("a_drained", 64'(qa.size()), 64'(0));
        chk("b_drained", 64'(qb.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
